fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
- Sequences the instruction-fetch stage of the pipelined RV32I core.
- Owns the architectural fetch PC and issues one instruction-memory request at a time over a req/gnt/rvalid interface.
- Hands fetched instructions to IF/ID through a valid/ready handshake.
- Applies branch/jump redirects and trap redirects, and generates the front-end flush.

Parameters:
RESET_VECTOR, 32'h8000_0000, first fetch address after reset
PC_INC, 32'd4, sequential PC increment

Ports:
clk  input  1  clock
rst_n  input  1  reset, synchronous, active-low
redirect_valid_i  input  1  branch/jump taken, from EX
redirect_pc_i  input  32  redirect target
trap_valid_i  input  1  trap/exception taken
trap_pc_i  input  32  trap vector (mtvec)
imem_req_o  output  1  fetch request
imem_addr_o  output  32  fetch address
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  response data valid
imem_rdata_i  input  32  response instruction word
inst_valid_o  output  1  instruction valid to IF/ID
inst_ready_i  input  1  IF/ID can accept (0 = hazard stall)
inst_o  output  32  instruction word
inst_pc_o  output  32  PC of inst_o
pc_o  output  32  current fetch PC
flush_o  output  1  one-cycle pulse: kill younger instructions in IF/ID
misalign_o  output  1  one-cycle pulse: redirect target bits[1:0] != 0

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=BOOT, pc_o=0.
  - All other outputs 0; kill flag and buffer cleared.
  - Reset mid-operation abandons any outstanding request; a later imem_rvalid_i is ignored until the next grant.
- States: BOOT, FETCH, WAIT, HOLD.
- BOOT: lasts one cycle; pc_o <= RESET_VECTOR; go to FETCH.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc_o.
  - On imem_gnt_i, go to WAIT.
  - imem_addr_o must stay stable while ungranted.
- WAIT:
  - imem_req_o=0.
  - On imem_rvalid_i with kill=1: drop the data, clear kill, go to FETCH.
  - On imem_rvalid_i with kill=0: latch inst_o=imem_rdata_i and inst_pc_o=pc_o, assert inst_valid_o, pc_o <= pc_o+PC_INC (mod 2^32; wrap from 0xFFFF_FFFC to 0), go to HOLD.
- HOLD:
  - inst_valid_o=1; inst_o and inst_pc_o hold stable.
  - On inst_ready_i, deassert inst_valid_o next cycle and go to FETCH.
  - While inst_ready_i=0, remain in HOLD indefinitely.
- Throughput: at most one instruction per 3 cycles with zero-latency memory (FETCH -> WAIT -> HOLD). No prefetch in this revision.
- Redirect priority: trap > redirect > sequential. Applies in FETCH, WAIT and HOLD; BOOT ignores both.
- On an accepted trap or redirect:
  - pc_o <= target next cycle; flush_o=1 in the same cycle as the input.
  - FETCH without imem_gnt_i: request withdrawn, stay in FETCH; the new address appears next cycle.
  - FETCH with imem_gnt_i in the same cycle: the old request is committed; go to WAIT with kill=1.
  - WAIT without imem_rvalid_i: kill=1, stay in WAIT.
  - WAIT with imem_rvalid_i in the same cycle: drop the data, go to FETCH.
  - HOLD: drop the buffered instruction; inst_valid_o=0 next cycle; go to FETCH, even if inst_ready_i=1 the same cycle (the handoff still occurs, and IF/ID is flushed by flush_o).
- Misaligned target (bits[1:0] != 0): pc_o <= {target[31:2],2'b00} and misalign_o pulses in the same cycle as flush_o. trap_pc_i is also aligned the same way.
- trap_valid_i and redirect_valid_i together: trap target used, single flush_o pulse.
- Outputs are registered, except imem_req_o/imem_addr_o (decoded from state and pc_o) and flush_o/misalign_o (combinational from inputs, gated by state != BOOT).

Test Plan:
- Boot: release rst_n, memory grants immediately with 1-cycle rvalid returning 0x0000_0013 -> pc_o 0, then 0x8000_0000; first imem_addr_o=0x8000_0000; inst_pc_o=0x8000_0000; then addresses 0x8000_0004, 0x8000_0008.
- Stall: hold inst_ready_i=0 for 5 cycles in HOLD -> inst_o/inst_pc_o stable, imem_req_o=0 throughout; the next request goes to pc+4 only after ready.
- Redirect in WAIT: redirect_pc_i=0x8000_0100 one cycle before rvalid -> flush_o pulse, response dropped (inst_valid_o stays 0), next imem_addr_o=0x8000_0100.
- Simultaneous trap and redirect in FETCH with gnt=1: trap_pc_i=0x8000_0040, redirect 0x8000_0200 -> one flush_o, kill set, stale rvalid dropped, next fetch at 0x8000_0040.
- Misaligned redirect to 0x8000_0102 -> misalign_o=1 for one cycle, next fetch 0x8000_0100.
- Reset mid-WAIT with late rvalid arriving 2 cycles after reset deasserts -> rvalid ignored, clean boot fetch at 0x8000_0000; plus wrap test: pc 0xFFFF_FFFC fetch -> next address 0x0000_0000.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for the RV32I pipeline.
//
// Owns the architectural fetch PC. It issues one instruction-memory request
// at a time, waits for the response and hands the instruction to IF/ID. It
// also applies branch/jump and trap redirects and raises the front-end flush.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   redirect_valid_i/_pc_i     taken branch/jump from EX and its target
//   trap_valid_i/trap_pc_i     trap taken and its vector (mtvec)
//   imem_req_o/imem_addr_o     fetch request and address (address = pc_o)
//   imem_gnt_i                 request accepted this cycle
//   imem_rvalid_i/_rdata_i     response valid and instruction word
//   inst_valid_o/inst_ready_i  instruction handoff to IF/ID
//   inst_o/inst_pc_o           buffered instruction and its PC
//   pc_o                       current fetch PC
//   flush_o                    pulse: kill younger instructions in IF/ID
//   misalign_o                 pulse: redirect target had bits[1:0] != 0
//   dbg_state_o                FSM state (0=BOOT 1=FETCH 2=WAIT 3=HOLD)
//
// Handshakes:
//   imem: a request is transferred in any cycle with imem_req_o && imem_gnt_i.
//   Exactly one response (imem_rvalid_i) follows each granted request.
//   IF/ID: an instruction transfers in any cycle with inst_valid_o &&
//   inst_ready_i. inst_o/inst_pc_o hold stable while inst_valid_o is high
//   and not yet accepted.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000,
  parameter logic [31:0] PC_INC       = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_valid_i,
  input  logic [31:0] trap_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  output logic [31:0] pc_o,
  output logic        flush_o,
  output logic        misalign_o,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        inst_valid_q;
  // Set when the outstanding response belongs to a redirected-away path.
  logic        kill_q;

  logic        take;
  logic [31:0] target_raw;
  logic [31:0] target_al;

  // Trap wins over redirect; BOOT ignores both so the boot fetch is clean.
  assign take       = (state_q != BOOT) && (trap_valid_i || redirect_valid_i);
  assign target_raw = trap_valid_i ? trap_pc_i : redirect_pc_i;
  assign target_al  = {target_raw[31:2], 2'b00};

  assign flush_o      = take;
  assign misalign_o   = take && (target_raw[1:0] != 2'b00);
  assign imem_req_o   = (state_q == FETCH);
  // The address is the PC itself, so it cannot move while a request waits
  // for a grant unless a redirect changes the PC.
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = inst_valid_q;
  assign dbg_state_o  = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= BOOT;
      pc_q         <= 32'd0;
      inst_q       <= 32'd0;
      inst_pc_q    <= 32'd0;
      inst_valid_q <= 1'b0;
      kill_q       <= 1'b0;
    end else begin
      case (state_q)
        BOOT: begin
          pc_q    <= RESET_VECTOR;
          state_q <= FETCH;
        end

        FETCH: begin
          if (take) begin
            pc_q <= target_al;
            // A grant in the redirect cycle commits the old request; its
            // response must be thrown away when it arrives.
            if (imem_gnt_i) begin
              state_q <= WAIT;
              kill_q  <= 1'b1;
            end
          end else if (imem_gnt_i) begin
            state_q <= WAIT;
          end
        end

        WAIT: begin
          if (take) begin
            pc_q <= target_al;
            if (imem_rvalid_i) begin
              kill_q  <= 1'b0;
              state_q <= FETCH;
            end else begin
              kill_q <= 1'b1;
            end
          end else if (imem_rvalid_i) begin
            if (kill_q) begin
              kill_q  <= 1'b0;
              state_q <= FETCH;
            end else begin
              inst_q       <= imem_rdata_i;
              inst_pc_q    <= pc_q;
              inst_valid_q <= 1'b1;
              pc_q         <= pc_q + PC_INC;
              state_q      <= HOLD;
            end
          end
        end

        HOLD: begin
          // A redirect drops the buffered instruction; if IF/ID accepts it
          // in the same cycle, flush_o kills it there.
          if (take) begin
            pc_q         <= target_al;
            inst_valid_q <= 1'b0;
            state_q      <= FETCH;
          end else if (inst_ready_i) begin
            inst_valid_q <= 1'b0;
            state_q      <= FETCH;
          end
        end

        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic        trap_valid_i;
  logic [31:0] trap_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic [31:0] pc_o;
  logic        flush_o;
  logic        misalign_o;
  logic [1:0]  dbg_state_o;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .trap_valid_i     (trap_valid_i),
    .trap_pc_i        (trap_pc_i),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_o           (inst_o),
    .inst_pc_o        (inst_pc_o),
    .pc_o             (pc_o),
    .flush_o          (flush_o),
    .misalign_o       (misalign_o),
    .dbg_state_o      (dbg_state_o)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [63:0] exp_q[$];  // {pc, instruction} expected at IF/ID handoff

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic rst, input logic gnt, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic red, input logic [31:0] rpc,
                       input logic trp, input logic [31:0] tpc);
    rst_n            = rst;
    imem_gnt_i       = gnt;
    imem_rvalid_i    = rv;
    imem_rdata_i     = rd;
    inst_ready_i     = rdy;
    redirect_valid_i = red;
    redirect_pc_i    = rpc;
    trap_valid_i     = trp;
    trap_pc_i        = tpc;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        rst, gnt, rv;
    logic [31:0] rd;
    logic        rdy, red;
    logic [31:0] rpc;
    logic        trp;
    logic [31:0] tpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst, e_ipc, e_pc;
    logic        e_fl, e_mis;
  } vec_t;

  vec_t vec[$];

  task automatic row(input logic rst, input logic gnt, input logic rv, input logic [31:0] rd,
                     input logic rdy, input logic red, input logic [31:0] rpc,
                     input logic trp, input logic [31:0] tpc,
                     input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                     input logic [31:0] e_inst, input logic [31:0] e_ipc,
                     input logic [31:0] e_pc, input logic e_fl, input logic e_mis);
    vec_t v;
    v.rst = rst; v.gnt = gnt; v.rv = rv; v.rd = rd; v.rdy = rdy; v.red = red; v.rpc = rpc;
    v.trp = trp; v.tpc = tpc; v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv;
    v.e_inst = e_inst; v.e_ipc = e_ipc; v.e_pc = e_pc; v.e_fl = e_fl; v.e_mis = e_mis;
    vec.push_back(v);
  endtask

  // Random-phase reference model state (transaction level).
  logic [31:0] pc_exp;
  logic        outstanding, stale, buffered;
  logic [31:0] out_addr;
  int          cnt;
  localparam logic [31:0] KEY = 32'h1357_9BDF;

  initial begin
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);

    //   rst g  v  rdata         rdy red rpc           trp tpc           req addr          iv inst          ipc           pc            fl mis
    // boot; redirect during BOOT is ignored
    row(1, 0, 0, 32'h0,        0, 1, 32'h8000_0200, 0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0, 0);
    row(1, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h8000_0000, 0, 0);
    row(1, 0, 1, 32'h13,       0, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h8000_0000, 0, 0);
    // five stall cycles in HOLD, then accept
    for (int i = 0; i < 5; i++)
      row(1, 0, 0, 32'h0,      0, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0004, 1, 32'h13,       32'h8000_0000, 32'h8000_0004, 0, 0);
    row(1, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0004, 1, 32'h13,       32'h8000_0000, 32'h8000_0004, 0, 0);
    // ungranted request keeps its address
    row(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0004, 0, 32'h13,       32'h8000_0000, 32'h8000_0004, 0, 0);
    row(1, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0004, 0, 32'h13,       32'h8000_0000, 32'h8000_0004, 0, 0);
    row(1, 0, 1, 32'h0010_0093,0, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0004, 0, 32'h13,       32'h8000_0000, 32'h8000_0004, 0, 0);
    row(1, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0008, 1, 32'h0010_0093, 32'h8000_0004, 32'h8000_0008, 0, 0);
    row(1, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0008, 0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0008, 0, 0);
    // redirect in WAIT one cycle before rvalid
    row(1, 0, 0, 32'h0,        0, 1, 32'h8000_0100, 0, 32'h0,        0, 32'h8000_0008, 0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0008, 1, 0);
    row(1, 0, 1, 32'hDEAD_BEEF,0, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0100, 0, 0);
    // trap + redirect together in FETCH with grant
    row(1, 1, 0, 32'h0,        0, 1, 32'h8000_0200, 1, 32'h8000_0040, 1, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0100, 1, 0);
    row(1, 0, 1, 32'h0000_0BAD,0, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0040, 0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0040, 0, 0);
    // misaligned redirect in FETCH without grant
    row(1, 0, 0, 32'h0,        0, 1, 32'h8000_0102, 0, 32'h0,        1, 32'h8000_0040, 0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0040, 1, 1);
    row(1, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0100, 0, 0);
    row(1, 0, 1, 32'h0000_0073,0, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0100, 0, 32'h0010_0093, 32'h8000_0004, 32'h8000_0100, 0, 0);
    // misaligned trap in HOLD together with ready
    row(1, 0, 0, 32'h0,        1, 0, 32'h0,         1, 32'h8000_0003, 0, 32'h8000_0104, 1, 32'h73,       32'h8000_0100, 32'h8000_0104, 1, 1);
    row(1, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0000, 0, 32'h73,       32'h8000_0100, 32'h8000_0000, 0, 0);
    // reset mid-WAIT, late rvalid after reset is ignored
    row(0, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0000, 0, 32'h73,       32'h8000_0100, 32'h8000_0000, 0, 0);
    row(1, 0, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        0, 32'h0,         0, 32'h0,        32'h0,        32'h0,        0, 0);
    row(1, 0, 1, 32'h0000_0BAD,0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h8000_0000, 0, 0);
    row(1, 0, 1, 32'h0000_0BAD,0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h8000_0000, 0, 0);
    row(1, 1, 0, 32'h0,        0, 0, 32'h0,         0, 32'h0,        1, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h8000_0000, 0, 0);
    row(1, 0, 1, 32'h13,       0, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0000, 0, 32'h0,        32'h0,        32'h8000_0000, 0, 0);
    row(1, 0, 0, 32'h0,        1, 0, 32'h0,         0, 32'h0,        0, 32'h8000_0004, 1, 32'h13,       32'h8000_0000, 32'h8000_0004, 0, 0);

    foreach (vec[i]) begin
      @(negedge clk);
      drive(vec[i].rst, vec[i].gnt, vec[i].rv, vec[i].rd, vec[i].rdy, vec[i].red, vec[i].rpc,
            vec[i].trp, vec[i].tpc);
      #1;
      if (i == 0) chk("boot_dbg_state", {30'd0, dbg_state_o}, 32'd0);
      chk($sformatf("v%0d_req", i),      {31'd0, imem_req_o},   {31'd0, vec[i].e_req});
      chk($sformatf("v%0d_addr", i),     imem_addr_o,           vec[i].e_addr);
      chk($sformatf("v%0d_ivalid", i),   {31'd0, inst_valid_o}, {31'd0, vec[i].e_iv});
      chk($sformatf("v%0d_inst", i),     inst_o,                vec[i].e_inst);
      chk($sformatf("v%0d_inst_pc", i),  inst_pc_o,             vec[i].e_ipc);
      chk($sformatf("v%0d_pc", i),       pc_o,                  vec[i].e_pc);
      chk($sformatf("v%0d_flush", i),    {31'd0, flush_o},      {31'd0, vec[i].e_fl});
      chk($sformatf("v%0d_misalign", i), {31'd0, misalign_o},   {31'd0, vec[i].e_mis});
    end

    // ---------------- wrap sequence: fetch at 0xFFFF_FFFC ----------------
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    #1 chk("wrap_flush", {31'd0, flush_o}, 32'd1);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(1, 0, 1, 32'h0000_0013, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 1, 0, 0, 0, 0);
    #1;
    chk("wrap_pc", pc_o, 32'h0);
    chk("wrap_inst_pc", inst_pc_o, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_req", {31'd0, imem_req_o}, 32'd1);
    chk("wrap_next_addr", imem_addr_o, 32'h0);

    // ---------------- randomized phase vs transaction model ----------------
    pc_exp = 32'h0; outstanding = 0; stale = 0; buffered = 0; out_addr = 0; cnt = 0;
    for (int c = 0; c < 600; c++) begin
      logic rv, take, rdy, gnt;
      logic [31:0] tgt;
      int r;
      @(negedge clk);
      chk("rnd_pc", pc_o, pc_exp);
      chk("rnd_req", {31'd0, imem_req_o}, {31'd0, !outstanding && !buffered});
      chk("rnd_ivalid", {31'd0, inst_valid_o}, {31'd0, buffered});
      if (!outstanding && !buffered) chk("rnd_addr", imem_addr_o, pc_exp);

      rv = outstanding && (cnt == 0);
      if (outstanding && cnt != 0) cnt--;
      gnt = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 15);
      drive(1'b1, gnt, rv, rv ? (out_addr ^ KEY) : $urandom, rdy,
            (r <= 2), {16'h8000, 16'($urandom)}, (r == 0), {16'h8000, 16'($urandom)});
      #1;
      take = trap_valid_i || redirect_valid_i;
      tgt  = trap_valid_i ? trap_pc_i : redirect_pc_i;
      chk("rnd_flush", {31'd0, flush_o}, {31'd0, take});
      chk("rnd_misalign", {31'd0, misalign_o}, {31'd0, take && (tgt[1:0] != 2'b00)});

      if (!outstanding && !buffered) begin
        if (gnt) begin
          outstanding = 1; out_addr = pc_exp; stale = take; cnt = $urandom_range(0, 2);
        end
      end else if (outstanding) begin
        if (rv) begin
          outstanding = 0;
          if (!stale && !take) begin
            buffered = 1;
            exp_q.push_back({out_addr, out_addr ^ KEY});
            pc_exp = pc_exp + 32'd4;
          end
        end else if (take) begin
          stale = 1;
        end
      end else begin
        if (rdy || take) begin
          if (exp_q.size() == 0) begin
            chk("rnd_queue_empty", 32'd1, 32'd0);
          end else begin
            logic [63:0] e;
            e = exp_q.pop_front();
            if (rdy) begin
              chk("rnd_inst", inst_o, e[31:0]);
              chk("rnd_inst_pc", inst_pc_o, e[63:32]);
            end
          end
          buffered = 0;
        end
      end
      if (take) pc_exp = {tgt[31:2], 2'b00};
    end

    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
